regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//   Shares the single RegisterFile write port (RW/BusW/RegWr) between two writeback requesters:
//   port 0 = main pipeline WB, port 1 = multi-cycle unit (MUL/DIV/LD miss).
//   Fixed priority to port 0, with a starvation guard for port 1. One registered output stage.
//   Holds a 32-entry busy scoreboard so issue logic stalls on registers with writes in flight.
// PARAMETERS
//   DATA_W        64  width of write data / BusW
//   ADDR_W        5   register index width
//   STARVE_LIMIT  4   consecutive lost cycles before port 1 is forced to win; legal range >= 1
//   ZERO_REG      31  XZR index: writes are accepted but suppressed, never marked busy
// PORTS
//   Clk         in   1       clock, all state updates on posedge
//   Reset       in   1       asynchronous, active-high
//   Wr0Valid    in   1       port 0 write request
//   Wr0Ready    out  1       port 0 accepted this cycle (combinational)
//   Wr0Reg      in   ADDR_W  port 0 destination register
//   Wr0Data     in   DATA_W  port 0 write data
//   Wr1Valid    in   1       port 1 write request
//   Wr1Ready    out  1       port 1 accepted this cycle (combinational)
//   Wr1Reg      in   ADDR_W  port 1 destination register
//   Wr1Data     in   DATA_W  port 1 write data
//   AllocValid  in   1       issue logic reserves a destination register
//   AllocReg    in   ADDR_W  register being reserved
//   Busy        out  32      bit r = 1: write to r pending (registered)
//   RW          out  ADDR_W  to RegisterFile.RW (registered)
//   BusW        out  DATA_W  to RegisterFile.BusW (registered)
//   RegWr       out  1       to RegisterFile.RegWr (registered)
// BEHAVIOUR
//   Reset (async, any cycle): RegWr=0, RW=0, BusW=0, Busy=0, StarveCnt=0. Staged write is dropped.
//   Handshake: a transfer happens when Valid & Ready are both high at posedge.
//     Ready depends on Valid; a requester holds Valid/Reg/Data stable until it sees Ready.
//   Grant rule:
//     - StarveCnt == STARVE_LIMIT & Wr1Valid -> grant port 1.
//     - else Wr0Valid -> grant port 0.
//     - else Wr1Valid -> grant port 1.
//     - At most one Ready is high per cycle. No bubble: back-to-back grants every cycle.
//   StarveCnt:
//     - +1 (saturating at STARVE_LIMIT) each cycle Wr1Valid & !Wr1Ready.
//     - Clears to 0 on a port 1 grant or when Wr1Valid = 0.
//   Output stage:
//     - Grant at edge N loads RW/BusW from the winner; RegWr = (Reg != ZERO_REG).
//     - No grant -> RegWr = 0; RW/BusW hold.
//     - RegisterFile commits at edge N+1. Total latency accept->commit = 1 cycle.
//   Same-register, same-cycle requests: port 0 commits first and port 1 the next cycle.
//     The last committed value wins. Issue logic must not allow this.
//   Scoreboard:
//     - Set Busy[AllocReg] at posedge when AllocValid & AllocReg != ZERO_REG.
//     - Clear Busy[RW] at posedge when RegWr = 1, i.e. the same edge the RegisterFile writes.
//     - Same-edge set and clear of one register -> set wins (new allocation).
//     - Busy[ZERO_REG] is always 0. Write to a non-busy register is legal and leaves Busy unchanged.
//   Widths: no arithmetic on data. StarveCnt width = $clog2(STARVE_LIMIT+1).
// STRUCTURE
//   Package regfile_pkg: DATA_W, ADDR_W, NUM_REGS = 32, ZERO_REG = 31 constants.
//   Shared with RegisterFile and the decoder.
//   Sub-module wb_scoreboard: Busy vector with set/clear ports; arbiter + output regs stay top-level.
// TESTING
//   1. Reset mid-write: assert Reset while RegWr=1 -> RegWr, Busy, RW, BusW go 0 immediately, no commit.
//   2. Wr0 only, Reg=5, Data=64'hA5A5:
//      Wr0Ready same cycle; next cycle RW=5, BusW=A5A5, RegWr=1; BusA reads A5A5 after the commit edge.
//   3. Both valid, Wr0 held 6 cycles, STARVE_LIMIT=4:
//      grants 0,0,0,0,1,0; StarveCnt returns to 0 after the port 1 grant.
//   4. Alloc Reg=7, then Wr1 Reg=7:
//      Busy[7] set the next cycle, clears on the RegWr edge; Alloc 7 on that edge keeps Busy[7]=1.
//   5. Write Reg=31, Data=DEADBEEF: Ready=1, RegWr stays 0, BusA(31)=0.
//      Alloc 31 -> Busy[31] stays 0.
//   6. Random 1000-cycle Valid traffic vs a reference model:
//      every accepted write commits exactly once, in grant order, at most one Ready per cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: register file geometry shared by the RegisterFile, decoder and writeback arbiter
package regfile_pkg;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register busy bits, set on allocation and cleared on register file commit
module wb_scoreboard
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [ADDR_W-1:0]   set_reg,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_reg,
  output logic [NUM_REGS-1:0] busy
);
  logic [NUM_REGS-1:0] set_mask, clr_mask;
  always_comb begin
    set_mask = (set_en && set_reg != ZERO_REG) ? NUM_REGS'(1) << set_reg : '0;
    clr_mask = clr_en ? NUM_REGS'(1) << clr_reg : '0;
  end
  // set is applied after clear so a fresh allocation survives a same-edge commit
  always_ff @(posedge clk or posedge rst)
    if (rst) busy <= '0;
    else busy <= (busy & ~clr_mask) | set_mask;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between pipeline WB and the multi-cycle unit
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Wr0Valid,
  output logic                Wr0Ready,
  input  logic [ADDR_W-1:0]   Wr0Reg,
  input  logic [DATA_W-1:0]   Wr0Data,
  input  logic                Wr1Valid,
  output logic                Wr1Ready,
  input  logic [ADDR_W-1:0]   Wr1Reg,
  input  logic [DATA_W-1:0]   Wr1Data,
  input  logic                AllocValid,
  input  logic [ADDR_W-1:0]   AllocReg,
  output logic [NUM_REGS-1:0] Busy,
  output logic [ADDR_W-1:0]   RW,
  output logic [DATA_W-1:0]   BusW,
  output logic                RegWr
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;
  logic starved, grant0, grant1, granted;
  logic [ADDR_W-1:0] win_reg;
  logic [DATA_W-1:0] win_data;
  always_comb begin
    starved = starve_cnt == CNT_W'(STARVE_LIMIT);
    grant1 = Wr1Valid & (starved | ~Wr0Valid);
    grant0 = Wr0Valid & ~grant1;
    granted = grant0 | grant1;
    win_reg = grant1 ? Wr1Reg : Wr0Reg;
    win_data = grant1 ? Wr1Data : Wr0Data;
  end
  assign Wr0Ready = grant0;
  assign Wr1Ready = grant1;
  // writes to the zero register are accepted but never raise RegWr
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      starve_cnt <= '0;
      RW <= '0;
      BusW <= '0;
      RegWr <= 1'b0;
    end else begin
      starve_cnt <= (!Wr1Valid || grant1) ? '0 : starved ? starve_cnt : starve_cnt + 1'b1;
      RegWr <= granted && win_reg != ZERO_REG;
      if (granted) begin
        RW <= win_reg;
        BusW <= win_data;
      end
    end
  wb_scoreboard u_scoreboard (
    .clk     (Clk),
    .rst     (Reset),
    .set_en  (AllocValid),
    .set_reg (AllocReg),
    .clr_en  (RegWr),
    .clr_reg (RW),
    .busy    (Busy)
  );
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and randomized checks of the writeback arbiter against a reference model
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;
  localparam int LIM = 4;
  logic Clk = 1'b0, Reset = 1'b1;
  logic Wr0Valid = 0, Wr1Valid = 0, AllocValid = 0;
  logic Wr0Ready, Wr1Ready, RegWr;
  logic [ADDR_W-1:0] Wr0Reg = 0, Wr1Reg = 0, AllocReg = 0, RW;
  logic [DATA_W-1:0] Wr0Data = 0, Wr1Data = 0, BusW;
  logic [NUM_REGS-1:0] Busy;
  logic [DATA_W-1:0] rf [NUM_REGS];
  int total = 0, bad = 0;

  regfile_wb_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .Clk(Clk), .Reset(Reset),
    .Wr0Valid(Wr0Valid), .Wr0Ready(Wr0Ready), .Wr0Reg(Wr0Reg), .Wr0Data(Wr0Data),
    .Wr1Valid(Wr1Valid), .Wr1Ready(Wr1Ready), .Wr1Reg(Wr1Reg), .Wr1Data(Wr1Data),
    .AllocValid(AllocValid), .AllocReg(AllocReg),
    .Busy(Busy), .RW(RW), .BusW(BusW), .RegWr(RegWr)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) if (RegWr && RW != ZERO_REG) rf[RW] <= BusW;

  function automatic logic [DATA_W-1:0] bus_a(input logic [ADDR_W-1:0] r);
    return r == ZERO_REG ? '0 : rf[r];
  endfunction

  task automatic drive(input logic v0, input logic [ADDR_W-1:0] r0, input logic [DATA_W-1:0] d0,
                       input logic v1, input logic [ADDR_W-1:0] r1, input logic [DATA_W-1:0] d1,
                       input logic av, input logic [ADDR_W-1:0] ar);
    @(negedge Clk);
    Wr0Valid = v0; Wr0Reg = r0; Wr0Data = d0;
    Wr1Valid = v1; Wr1Reg = r1; Wr1Data = d1;
    AllocValid = av; AllocReg = ar;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic after_edge();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (RegWr !== 0 || RW !== 0 || BusW !== 0 || Busy !== 0) begin
      bad++; $display("FAIL reset_init: RegWr=%b RW=%0d BusW=%h Busy=%h want all 0", RegWr, RW, BusW, Busy);
    end
    @(negedge Clk); Reset = 0;
    drive(1, 3, 64'h1234, 0, 0, 0, 1, 3);
    total++;
    if (Wr0Ready !== 1) begin bad++; $display("FAIL reset_wr0ready: got %b want 1", Wr0Ready); end
    after_edge();
    total++;
    if (RegWr !== 1 || Busy[3] !== 1) begin
      bad++; $display("FAIL reset_prewrite: RegWr=%b Busy3=%b want 1 1", RegWr, Busy[3]);
    end
    #2 Reset = 1;
    #1;
    total++;
    if (RegWr !== 0 || RW !== 0 || BusW !== 0 || Busy !== 0) begin
      bad++; $display("FAIL reset_midwrite: RegWr=%b RW=%0d BusW=%h Busy=%h want all 0", RegWr, RW, BusW, Busy);
    end
    @(negedge Clk); Reset = 0; Wr0Valid = 0; AllocValid = 0;
    after_edge();
    total++;
    if (bus_a(3) !== 0 || RegWr !== 0) begin
      bad++; $display("FAIL reset_nocommit: rf3=%h RegWr=%b want 0 0", bus_a(3), RegWr);
    end
  endtask

  task automatic test_single();
    drive(1, 5, 64'hA5A5, 0, 0, 0, 0, 0);
    total++;
    if (Wr0Ready !== 1 || Wr1Ready !== 0) begin
      bad++; $display("FAIL single_ready: r0=%b r1=%b want 1 0", Wr0Ready, Wr1Ready);
    end
    after_edge();
    total++;
    if (RW !== 5 || BusW !== 64'hA5A5 || RegWr !== 1) begin
      bad++; $display("FAIL single_out: RW=%0d BusW=%h RegWr=%b want 5 a5a5 1", RW, BusW, RegWr);
    end
    idle();
    after_edge();
    total++;
    if (bus_a(5) !== 64'hA5A5 || RegWr !== 0 || RW !== 5 || BusW !== 64'hA5A5) begin
      bad++; $display("FAIL single_commit: rf5=%h RegWr=%b RW=%0d BusW=%h want a5a5 0 5 a5a5", bus_a(5), RegWr, RW, BusW);
    end
  endtask

  task automatic test_starve();
    int acc0 = 0;
    logic exp1;
    for (int i = 0; i < 11; i++) begin
      drive(1, ADDR_W'(10 + acc0), DATA_W'(acc0), 1, ADDR_W'(20 + i), DATA_W'(100 + i), 0, 0);
      exp1 = (i == 4 || i == 9);
      total++;
      if (Wr1Ready !== exp1 || Wr0Ready !== !exp1) begin
        bad++; $display("FAIL starve_grant%0d: r0=%b r1=%b want r1=%b", i, Wr0Ready, Wr1Ready, exp1);
      end
      after_edge();
      total++;
      if (RegWr !== 1 || RW !== (exp1 ? ADDR_W'(20 + i) : ADDR_W'(10 + acc0))) begin
        bad++; $display("FAIL starve_out%0d: RegWr=%b RW=%0d", i, RegWr, RW);
      end
      if (!exp1) acc0++;
    end
    idle();
    after_edge();
  endtask

  task automatic test_scoreboard();
    drive(0, 0, 0, 0, 0, 0, 1, 7);
    after_edge();
    total++;
    if (Busy !== 32'h80) begin bad++; $display("FAIL sb_set: Busy=%h want 80", Busy); end
    drive(0, 0, 0, 1, 7, 64'h77, 0, 0);
    total++;
    if (Wr1Ready !== 1) begin bad++; $display("FAIL sb_wr1ready: got %b want 1", Wr1Ready); end
    after_edge();
    total++;
    if (RegWr !== 1 || Busy[7] !== 1) begin
      bad++; $display("FAIL sb_pending: RegWr=%b Busy7=%b want 1 1", RegWr, Busy[7]);
    end
    idle();
    after_edge();
    total++;
    if (Busy !== 0 || bus_a(7) !== 64'h77) begin
      bad++; $display("FAIL sb_clear: Busy=%h rf7=%h want 0 77", Busy, bus_a(7));
    end
    drive(0, 0, 0, 0, 0, 0, 1, 7);
    after_edge();
    drive(0, 0, 0, 1, 7, 64'h78, 0, 0);
    after_edge();
    drive(0, 0, 0, 0, 0, 0, 1, 7);
    after_edge();
    total++;
    if (Busy !== 32'h80) begin bad++; $display("FAIL sb_setwins: Busy=%h want 80", Busy); end
    idle();
    after_edge();
    total++;
    if (Busy !== 32'h80) begin bad++; $display("FAIL sb_hold: Busy=%h want 80", Busy); end
  endtask

  task automatic test_zero();
    drive(1, 31, 64'hDEADBEEF, 0, 0, 0, 0, 0);
    total++;
    if (Wr0Ready !== 1) begin bad++; $display("FAIL zero_ready: got %b want 1", Wr0Ready); end
    after_edge();
    total++;
    if (RegWr !== 0 || bus_a(31) !== 0) begin
      bad++; $display("FAIL zero_write: RegWr=%b rf31=%h want 0 0", RegWr, bus_a(31));
    end
    drive(0, 0, 0, 0, 0, 0, 1, 31);
    after_edge();
    total++;
    if (Busy[31] !== 0 || Busy !== 32'h80) begin
      bad++; $display("FAIL zero_alloc: Busy=%h want 80", Busy);
    end
    idle();
    after_edge();
  endtask

  task automatic test_random();
    logic v0 = 0, v1 = 0, av, g0, g1;
    logic [ADDR_W-1:0] r0 = 0, r1 = 0, ar, wreg;
    logic [DATA_W-1:0] d0 = 0, d1 = 0, wdata;
    logic [NUM_REGS-1:0] exp_busy = 32'h80;
    logic exp_regwr = 0;
    logic [ADDR_W-1:0] exp_rw = 31;
    logic [DATA_W-1:0] exp_busw = 64'hDEADBEEF;
    int lost = 0, accepted = 0, commits = 0;
    for (int c = 0; c < 1000; c++) begin
      if (!v0) begin v0 = 1'($urandom_range(0, 1)); r0 = ADDR_W'($urandom); d0 = {$urandom, $urandom}; end
      if (!v1) begin v1 = 1'($urandom_range(0, 1)); r1 = ADDR_W'($urandom); d1 = {$urandom, $urandom}; end
      av = $urandom_range(0, 3) == 0;
      ar = ADDR_W'($urandom);
      drive(v0, r0, d0, v1, r1, d1, av, ar);
      g1 = v1 && (lost >= LIM || !v0);
      g0 = v0 && !g1;
      total++;
      if (Wr0Ready !== g0 || Wr1Ready !== g1) begin
        bad++; $display("FAIL rand_grant c=%0d: r0=%b r1=%b want %b %b", c, Wr0Ready, Wr1Ready, g0, g1);
      end
      lost = (!v1 || g1) ? 0 : (lost < LIM ? lost + 1 : LIM);
      if (exp_regwr) exp_busy[exp_rw] = 1'b0;
      if (av && ar != ZERO_REG) exp_busy[ar] = 1'b1;
      wreg = g1 ? r1 : r0;
      wdata = g1 ? d1 : d0;
      exp_regwr = (g0 || g1) && wreg != ZERO_REG;
      if (g0 || g1) begin exp_rw = wreg; exp_busw = wdata; end
      if (exp_regwr) accepted++;
      if (g0) v0 = 0;
      if (g1) v1 = 0;
      after_edge();
      if (RegWr === 1) commits++;
      total++;
      if (RegWr !== exp_regwr || RW !== exp_rw || BusW !== exp_busw || Busy !== exp_busy) begin
        bad++;
        $display("FAIL rand_out c=%0d: RegWr=%b RW=%0d BusW=%h Busy=%h want %b %0d %h %h",
                 c, RegWr, RW, BusW, Busy, exp_regwr, exp_rw, exp_busw, exp_busy);
      end
    end
    idle();
    after_edge();
    total++;
    if (commits !== accepted) begin
      bad++; $display("FAIL rand_count: commits=%0d want %0d", commits, accepted);
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) rf[i] = '0;
    test_reset();
    test_single();
    test_starve();
    test_scoreboard();
    test_zero();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
